// File: rtl/pmux_pipe.sv
// pmux_pipe: registered one-hot parallel mux with a valid/ready output stage.
//   Selects channel i of b when s has exactly bit i set. Falls back to a when s is
//   zero or multi-hot. Accepted multi-hot selects are counted in a saturating
//   counter.
// Optional build macro: PMUX_PIPE_PRIORITY_EN. When it is defined, a multi-hot s
//   selects the lowest-index set bit instead of a. Such accepts are still counted.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   a                 default data (W)
//   b                 packed channels, channel i = b[i*W +: W] (N*W)
//   s                 select, expected one-hot or zero (N)
//   in_valid/in_ready input handshake; in_ready is combinational
//   out/out_valid     registered result and its valid flag
//   out_ready         downstream accepts out
//   sel_idx           registered channel index; N means a was used
//   err_cnt           saturating count of accepted multi-hot selects
module pmux_pipe #(
   parameter int unsigned W     = 4,
   parameter int unsigned N     = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [W-1:0]             a,
   input  logic [N*W-1:0]           b,
   input  logic [N-1:0]             s,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [W-1:0]             out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(N+1)-1:0]   sel_idx,
   output logic [CNT_W-1:0]         err_cnt
);

   localparam int unsigned IDX_W = $clog2(N+1);

   logic [W-1:0]     out_q, out_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic [IDX_W-1:0] low_idx;
   logic [W-1:0]     low_dat;
   logic [IDX_W-1:0] res_idx;
   logic [W-1:0]     res_dat;
   logic             multi_hot;
   logic             accept;
   logic             emit;

   // Lowest set bit of s. With no bit set, this is the default input and index N.
   always_comb begin
      low_idx = IDX_W'(N);
      low_dat = a;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (s[i]) begin
            low_idx = IDX_W'(i);
            low_dat = b[i*W +: W];
         end
      end
   end

   // Clearing the lowest set bit leaves a nonzero value only when two or more bits are set.
   assign multi_hot = |(s & (s - N'(1)));

   // Resolve the result when the select is multi-hot.
   always_comb begin
      res_idx = low_idx;
      res_dat = low_dat;
`ifdef PMUX_PIPE_PRIORITY_EN
      // Lowest-index channel wins; the illegal select is still counted below.
`else
      if (multi_hot) begin
         res_idx = IDX_W'(N);
         res_dat = a;
      end
`endif
   end

   // in_ready does not depend on in_valid.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign emit     = out_valid_q && out_ready;

   // Next state of the output register and of the error counter.
   always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      sel_idx_d   = sel_idx_q;
      err_cnt_d   = err_cnt_q;
      if (accept) begin
         out_d       = res_dat;
         sel_idx_d   = res_idx;
         out_valid_d = 1'b1;
      end else if (emit) begin
         out_valid_d = 1'b0;
      end
      if (accept && multi_hot && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sel_idx_q   <= '0;
         err_cnt_q   <= '0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sel_idx_q   <= sel_idx_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign sel_idx   = sel_idx_q;
   assign err_cnt   = err_cnt_q;

endmodule
